// File: rtl/compression_stream_sequencer_if.sv
// Stream-side handshake bundle for compression_stream_sequencer: uncompressed element
// input (s_*) and SHIFT_BYTES-wide compressed beat output (m_*).
interface compression_stream_sequencer_if #(
  parameter int UNCOMP_BYTES = 34,
  parameter int SHIFT_BYTES  = 8
);
  localparam int CW = $clog2(UNCOMP_BYTES);

  logic                      s_valid;
  logic                      s_ready;
  logic [UNCOMP_BYTES*8-1:0] s_data;
  logic [CW-1:0]             s_bytecount;
  logic                      s_last;

  logic                      m_valid;
  logic                      m_ready;
  logic [SHIFT_BYTES*8-1:0]  m_data;
  logic [SHIFT_BYTES-1:0]    m_keep;
  logic                      m_last;

  // The sequencer side: consumes elements, produces beats.
  modport slave (
    input  s_valid, s_data, s_bytecount, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  // The environment side: produces elements, consumes beats.
  modport master (
    output s_valid, s_data, s_bytecount, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/compression_stream_sequencer.sv
// Loads one element into an attached compressor, then drains its compressed output
// SHIFT_BYTES per beat, pulsing CSEShift on every output handshake.
module compression_stream_sequencer #(
  parameter  int UNCOMP_BYTES = 34,
  parameter  int COMP_BYTES   = 34,
  parameter  int SHIFT_BYTES  = 8,
  localparam int CW           = $clog2(UNCOMP_BYTES),
  localparam int KW           = $clog2(COMP_BYTES)
) (
  input  logic                         clk,
  input  logic                         resetn,
  compression_stream_sequencer_if.slave strm,
  output logic [UNCOMP_BYTES*8-1:0]    USEData,
  output logic [CW-1:0]                USEByteCount,
  input  logic [COMP_BYTES*8-1:0]      CSEData,
  input  logic [KW-1:0]                CSEByteCount,
  output logic                         CSEShift,
  output logic                         cmp_reset,
  output logic [31:0]                  elem_count
);

  // A byte count of CW bits must be able to hold UNCOMP_BYTES itself.
  if ((UNCOMP_BYTES & (UNCOMP_BYTES - 1)) == 0) begin : g_bad_uncomp
    $error("UNCOMP_BYTES must not be a power of two");
  end
  if (COMP_BYTES < SHIFT_BYTES) begin : g_bad_shift
    $error("COMP_BYTES must be at least SHIFT_BYTES");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                    state_q;
  logic [UNCOMP_BYTES*8-1:0] use_data_q;
  logic [CW-1:0]             use_cnt_q;
  logic                      last_q;
  logic [31:0]               elem_cnt_q;
  logic [1:0]                cmp_rst_sync_q;

  logic                      cse_empty;
  logic                      cse_fits;
  logic                      in_fire;
  logic                      out_fire;
  logic                      m_valid_w;
  logic [CW-1:0]             in_cnt_clamped;
  logic [SHIFT_BYTES-1:0]    keep_full;

  // Compressor reset: held through resetn and released on the 2nd clock after it lifts.
  // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmp_rst_sync_q <= 2'b00;
    end else begin
      cmp_rst_sync_q <= {cmp_rst_sync_q[0], 1'b1};
    end
  end

  assign cmp_reset = ~cmp_rst_sync_q[1];

  assign cse_empty = (CSEByteCount == '0);
  assign cse_fits  = (32'(CSEByteCount) <= 32'(SHIFT_BYTES));

  assign strm.s_ready = (state_q == ST_IDLE) && !cmp_reset;
  assign in_fire      = strm.s_valid && strm.s_ready;

  // The beat is live straight from the compressor's registers, so m_valid follows CSEByteCount.
  assign m_valid_w = (state_q == ST_DRAIN) && !cse_empty;
  assign out_fire  = m_valid_w && strm.m_ready;

  assign in_cnt_clamped = (32'(strm.s_bytecount) > 32'(UNCOMP_BYTES))
                          ? CW'(UNCOMP_BYTES) : strm.s_bytecount;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    keep_full = '0;
    for (int i = 0; i < SHIFT_BYTES; i++) begin
      keep_full[i] = (32'(CSEByteCount) > 32'(i));
    end
  end

  assign strm.m_valid = m_valid_w;
  assign strm.m_data  = m_valid_w ? CSEData[SHIFT_BYTES*8-1:0] : '0;
  assign strm.m_keep  = m_valid_w ? keep_full : '0;
  assign strm.m_last  = m_valid_w && last_q && cse_fits;
  assign CSEShift     = out_fire;

  if (COMP_BYTES > SHIFT_BYTES) begin : g_cse_hi
    logic unused_cse_hi;
    assign unused_cse_hi = ^CSEData[COMP_BYTES*8-1:SHIFT_BYTES*8];
  end

  // Sequencing FSM: IDLE accepts, LOAD presents the element for one cycle, DRAIN emits beats.
  // NOTE: the wide payload register is reset as well, so the compressor never sees X after power-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      use_data_q <= '0;
      use_cnt_q  <= '0;
      last_q     <= 1'b0;
      elem_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Zero-length elements are consumed and dropped, including their s_last.
          if (in_fire && (strm.s_bytecount != '0)) begin
            use_data_q <= strm.s_data;
            use_cnt_q  <= in_cnt_clamped;
            last_q     <= strm.s_last;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          use_cnt_q <= '0;
          state_q   <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // An empty compressor result on entry completes the element with no beat.
          if (cse_empty || (out_fire && cse_fits)) begin
            elem_cnt_q <= elem_cnt_q + 32'd1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign USEData      = use_data_q;
  assign USEByteCount = use_cnt_q;
  assign elem_count   = elem_cnt_q;

endmodule

// File: tb/tb_compression_stream_sequencer.sv
// Self-checking bench for compression_stream_sequencer with a stub compressor that passes data
// through uncompressed, except that an element whose first byte is 0xA5 compresses to nothing.
module tb_compression_stream_sequencer;

  localparam int UNCOMP_BYTES = 34;
  localparam int COMP_BYTES   = 34;
  localparam int SHIFT_BYTES  = 8;
  localparam int CW           = $clog2(UNCOMP_BYTES);
  localparam int KW           = $clog2(COMP_BYTES);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  compression_stream_sequencer_if #(.UNCOMP_BYTES(UNCOMP_BYTES), .SHIFT_BYTES(SHIFT_BYTES)) strm ();

  logic [UNCOMP_BYTES*8-1:0] use_data;
  logic [CW-1:0]             use_cnt;
  logic [COMP_BYTES*8-1:0]   cse_data;
  logic [KW-1:0]             cse_cnt;
  logic                      cse_shift;
  logic                      cmp_reset;
  logic [31:0]               elem_count;

  compression_stream_sequencer #(
    .UNCOMP_BYTES(UNCOMP_BYTES),
    .COMP_BYTES  (COMP_BYTES),
    .SHIFT_BYTES (SHIFT_BYTES)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .strm        (strm.slave),
    .USEData     (use_data),
    .USEByteCount(use_cnt),
    .CSEData     (cse_data),
    .CSEByteCount(cse_cnt),
    .CSEShift    (cse_shift),
    .cmp_reset   (cmp_reset),
    .elem_count  (elem_count)
  );

  // Stub compressor: synchronous reset, load has priority over shift.
  always @(posedge clk) begin
    if (cmp_reset) begin
      cse_data <= '0;
      cse_cnt  <= '0;
    end else if (use_cnt != '0) begin
      cse_data <= use_data;
      cse_cnt  <= (use_data[7:0] == 8'hA5) ? '0 : use_cnt;
    end else if (cse_shift) begin
      cse_data <= cse_data >> (SHIFT_BYTES*8);
      cse_cnt  <= (32'(cse_cnt) > SHIFT_BYTES) ? cse_cnt - KW'(SHIFT_BYTES) : '0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SHIFT_BYTES*8-1:0] data;
    logic [SHIFT_BYTES-1:0]   keep;
    logic                     last;
    int                       due;
  } beat_t;

  beat_t exp_q[$];
  bit    ready_script[$];
  bit    ready_rand = 1'b0;
  int    exp_elems = 0;
  int    stall_seen = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: clamp, then slice the element into SHIFT_BYTES beats.
  function automatic void model_push(input logic [UNCOMP_BYTES*8-1:0] d, input int bc,
                                     input logic last, input int due);
    int    n;
    int    nb;
    int    rem;
    beat_t bt;
    n = (bc > UNCOMP_BYTES) ? UNCOMP_BYTES : bc;
    if (n == 0) return;
    exp_elems++;
    if (d[7:0] == 8'hA5) return;
    nb = (n + SHIFT_BYTES - 1) / SHIFT_BYTES;
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      bt.keep = '0;
      rem = n - b * SHIFT_BYTES;
      for (int k = 0; k < SHIFT_BYTES; k++) begin
        if (b * SHIFT_BYTES + k < UNCOMP_BYTES) bt.data[k*8 +: 8] = d[(b*SHIFT_BYTES + k)*8 +: 8];
        bt.keep[k] = (k < rem);
      end
      bt.last = last && (b == nb - 1);
      bt.due  = (b == 0) ? due : -1;
      exp_q.push_back(bt);
    end
  endfunction

  function automatic logic [UNCOMP_BYTES*8-1:0] rand_data();
    logic [UNCOMP_BYTES*8-1:0] d;
    for (int i = 0; i < UNCOMP_BYTES; i++) d[i*8 +: 8] = 8'($urandom);
    if (d[7:0] == 8'hA5) d[7:0] = 8'h5A;
    return d;
  endfunction

  // Entered at a falling edge; returns at the falling edge where s_valid is dropped.
  task automatic send(input logic [UNCOMP_BYTES*8-1:0] d, input int bc, input logic last,
                      input int gap, input int stall_at, input int stall_len);
    int waited;
    waited = 0;
    repeat (gap) @(negedge clk);
    strm.s_valid     = 1'b1;
    strm.s_data      = d;
    strm.s_bytecount = CW'(bc);
    strm.s_last      = last;
    #1;
    while (!strm.s_ready) begin
      if (waited > 300) begin
        check("s_ready_timeout", 64'(strm.s_ready), 64'd1);
        strm.s_valid = 1'b0;
        return;
      end
      waited++;
      @(negedge clk);
      #1;
    end
    model_push(d, bc, last, cyc + 2);
    if (stall_len > 0) begin
      ready_script.push_back(1'b1);
      repeat (stall_at) ready_script.push_back(1'b1);
      repeat (stall_len) ready_script.push_back(1'b0);
    end
    @(negedge clk);
    strm.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !strm.s_ready) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_within_budget", 64'(exp_q.size() == 0 && strm.s_ready), 64'd1);
  endtask

  // Downstream ready: scripted stalls first, otherwise random or always ready.
  initial begin
    strm.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_script.size() != 0) strm.m_ready = ready_script.pop_front();
      else if (ready_rand)          strm.m_ready = ($urandom_range(0, 3) != 0);
      else                          strm.m_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    beat_t                    h;
    logic                     pv;
    logic [SHIFT_BYTES*8-1:0] pd;
    logic [SHIFT_BYTES-1:0]   pk;
    logic                     pl;
    pv = 1'b0;
    pd = '0;
    pk = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        pv = 1'b0;
        continue;
      end
      check("cse_shift_is_handshake", 64'(cse_shift), 64'(strm.m_valid & strm.m_ready));
      if (use_cnt != '0) check("no_shift_during_load", 64'(cse_shift), 64'd0);
      if (pv) begin
        check("stall_valid_held", 64'(strm.m_valid), 64'd1);
        check("stall_data_held", 64'(strm.m_data), 64'(pd));
        check("stall_keep_held", 64'({strm.m_keep, strm.m_last}), 64'({pk, pl}));
      end
      if (!strm.m_valid) begin
        check("idle_outputs_zero", 64'({strm.m_data == '0, strm.m_keep == '0, strm.m_last}), 64'b110);
      end else if (exp_q.size() == 0) begin
        check("beat_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        if (exp_q[0].due >= 0) begin
          check("first_beat_latency", 64'(cyc), 64'(exp_q[0].due));
          exp_q[0].due = -1;
        end
        if (strm.m_ready) begin
          h = exp_q.pop_front();
          check("beat_data", 64'(strm.m_data), 64'(h.data));
          check("beat_keep", 64'(strm.m_keep), 64'(h.keep));
          check("beat_last", 64'(strm.m_last), 64'(h.last));
        end else begin
          stall_seen++;
        end
      end
      pv = strm.m_valid & ~strm.m_ready;
      pd = strm.m_data;
      pk = strm.m_keep;
      pl = strm.m_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    strm.s_valid     = 1'b0;
    strm.s_data      = '0;
    strm.s_bytecount = '0;
    strm.s_last      = 1'b0;

    // Reset state and compressor reset release timing.
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", 64'(strm.s_ready), 64'd0);
    check("rst_m_valid", 64'(strm.m_valid), 64'd0);
    check("rst_cse_shift", 64'(cse_shift), 64'd0);
    check("rst_cmp_reset", 64'(cmp_reset), 64'd1);
    check("rst_elem_count", 64'(elem_count), 64'd0);
    check("rst_use_cnt", 64'(use_cnt), 64'd0);
    check("rst_use_data_zero", 64'(use_data == '0), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("cmp_reset_after_1st_edge", 64'(cmp_reset), 64'd1);
    check("s_ready_after_1st_edge", 64'(strm.s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("cmp_reset_after_2nd_edge", 64'(cmp_reset), 64'd0);
    check("s_ready_after_2nd_edge", 64'(strm.s_ready), 64'd1);
    @(negedge clk);

    // 20-byte element, no backpressure.
    send(rand_data(), 20, 1'b1, 0, 0, 0);
    wait_idle();
    check("elem_count_after_20B", 64'(elem_count), 64'(exp_elems));

    // Same element shape with a 3-cycle stall on the second beat.
    s0 = stall_seen;
    send(rand_data(), 20, 1'b1, 0, 1, 3);
    wait_idle();
    check("stall_cycles_seen", 64'(stall_seen - s0), 64'd3);
    check("elem_count_after_stall", 64'(elem_count), 64'(exp_elems));

    // Zero-length element is consumed without a load.
    send(rand_data(), 0, 1'b1, 0, 0, 0);
    #1;
    check("bc0_s_ready_stays", 64'(strm.s_ready), 64'd1);
    check("bc0_no_load", 64'(use_cnt), 64'd0);
    check("bc0_elem_count", 64'(elem_count), 64'(exp_elems));

    // Clamped oversize element, then exactly one beat.
    send(rand_data(), 40, 1'b0, 0, 0, 0);
    wait_idle();
    send(rand_data(), 8, 1'b1, 0, 0, 0);
    wait_idle();
    check("elem_count_after_clamp", 64'(elem_count), 64'(exp_elems));

    // Compressor produces nothing: element completes with no beat.
    begin
      logic [UNCOMP_BYTES*8-1:0] d;
      d = rand_data();
      d[7:0] = 8'hA5;
      send(d, 16, 1'b1, 0, 0, 0);
      wait_idle();
      check("elem_count_after_empty", 64'(elem_count), 64'(exp_elems));
    end

    // Randomized traffic with random backpressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [UNCOMP_BYTES*8-1:0] d;
      d = rand_data();
      if ($urandom_range(0, 7) == 0) d[7:0] = 8'hA5;
      send(d, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 2)), 0, 0);
    end
    wait_idle();
    ready_rand = 1'b0;
    check("elem_count_after_random", 64'(elem_count), 64'(exp_elems));

    // Reset in the middle of a stalled drain.
    send(rand_data(), 34, 1'b1, 0, 0, 30);
    @(negedge clk);
    #1;
    check("pre_reset_draining", 64'(strm.m_valid), 64'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    ready_script.delete();
    exp_elems = 0;
    #1;
    check("midrst_m_valid", 64'(strm.m_valid), 64'd0);
    check("midrst_cse_shift", 64'(cse_shift), 64'd0);
    check("midrst_cmp_reset", 64'(cmp_reset), 64'd1);
    check("midrst_s_ready", 64'(strm.s_ready), 64'd0);
    check("midrst_elem_count", 64'(elem_count), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_cmp_reset_1st", 64'(cmp_reset), 64'd1);
    @(posedge clk);
    #1;
    check("rerelease_idle_ready", 64'(strm.s_ready), 64'd1);
    @(negedge clk);
    send(rand_data(), 20, 1'b1, 0, 0, 0);
    wait_idle();
    check("elem_count_after_rerelease", 64'(elem_count), 64'(exp_elems));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
